// File: rtl/deskew_pkg.sv
// Shared types and defaults for the PCS deskew sequencer: state encoding,
// default sizing constants and the alignment-marker group classifier.
package deskew_pkg;

  localparam int DEF_N_LANES        = 20;
  localparam int DEF_DESKEW_TIMEOUT = 64;
  localparam int DEF_GOOD_AM_COUNT  = 2;
  localparam int DEF_BAD_AM_LIMIT   = 3;
  localparam int DEF_RESYNC_HOLD    = 4;
  localparam int DEF_MAX_RETRY      = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_DESKEW    = 3'd2,
    ST_VERIFY    = 3'd3,
    ST_ALIGNED   = 3'd4,
    ST_RESYNC    = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    AM_NONE    = 2'd0,
    AM_FULL    = 2'd1,
    AM_PARTIAL = 2'd2
  } am_class_e;

  // A group exists only on a valid cycle with at least one lane flagging an AM.
  function automatic am_class_e am_classify(input logic valid, input logic any_set,
                                            input logic all_set);
    if (!valid || !any_set) return AM_NONE;
    if (all_set) return AM_FULL;
    return AM_PARTIAL;
  endfunction

endpackage

// File: rtl/deskew_am_checker.sv
// Classifies post-deskew AM groups each cycle and owns the saturating
// good-group (VERIFY) and bad-group (ALIGNED) counters.
module deskew_am_checker
  import deskew_pkg::*;
#(
  parameter int N_LANES       = DEF_N_LANES,
  parameter int GOOD_AM_COUNT = DEF_GOOD_AM_COUNT,
  parameter int BAD_AM_LIMIT  = DEF_BAD_AM_LIMIT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_verify,
  input  logic               i_aligned,
  input  logic               i_valid,
  input  logic [N_LANES-1:0] i_aligned_am,
  output am_class_e          o_class,
  output logic               o_good_reached,
  output logic               o_bad_reached
);

  localparam int CNT_MAX = (GOOD_AM_COUNT > BAD_AM_LIMIT) ? GOOD_AM_COUNT : BAD_AM_LIMIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] good_q, good_d;
  logic [CW-1:0] bad_q, bad_d;
  am_class_e     cls;

  always_comb begin
    cls            = am_classify(i_valid, |i_aligned_am, &i_aligned_am);
    good_d         = good_q;
    bad_d          = bad_q;
    o_good_reached = 1'b0;
    o_bad_reached  = 1'b0;
    if (i_clear) begin
      good_d = '0;
      bad_d  = '0;
    end else if (i_verify && cls == AM_FULL) begin
      if (int'(good_q) < CNT_MAX) good_d = good_q + 1'b1;
      o_good_reached = (int'(good_q) + 1 >= GOOD_AM_COUNT);
    end else if (i_aligned) begin
      // Only consecutive partial groups count; any full group restarts the run.
      if (cls == AM_FULL) begin
        bad_d = '0;
      end else if (cls == AM_PARTIAL) begin
        if (int'(bad_q) < CNT_MAX) bad_d = bad_q + 1'b1;
        o_bad_reached = (int'(bad_q) + 1 >= BAD_AM_LIMIT);
      end
    end
  end

  assign o_class = cls;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

endmodule

// File: rtl/deskew_sequencer.sv
// Supervisory FSM for the 100GbE PCS deskew datapath: enable gating, timeout,
// alignment confirmation and bounded resync. Optional stats: DESKEW_SEQ_STATS_EN.
module deskew_sequencer
  import deskew_pkg::*;
#(
  parameter int N_LANES        = DEF_N_LANES,
  parameter int DESKEW_TIMEOUT = DEF_DESKEW_TIMEOUT,
  parameter int GOOD_AM_COUNT  = DEF_GOOD_AM_COUNT,
  parameter int BAD_AM_LIMIT   = DEF_BAD_AM_LIMIT,
  parameter int RESYNC_HOLD    = DEF_RESYNC_HOLD,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int NB_RETRY       = $clog2(MAX_RETRY + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [N_LANES-1:0]  i_am_lock,
  input  logic                i_deskew_done,
  input  logic                i_invalid_skew,
  input  logic [N_LANES-1:0]  i_aligned_am,
  output logic                o_deskew_enable,
  output logic [N_LANES-1:0]  o_resync,
  output logic                o_align_status,
  output logic                o_fail,
  output logic [NB_RETRY-1:0] o_retry_count,
  output logic [2:0]          o_state
`ifdef DESKEW_SEQ_STATS_EN
  ,
  output logic [15:0]         o_align_loss_count,
  output logic                o_timeout_seen
`endif
);

  localparam int TW = $clog2(DESKEW_TIMEOUT);
  localparam int HW = (RESYNC_HOLD > 1) ? $clog2(RESYNC_HOLD) : 1;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [NB_RETRY-1:0] retry_q, retry_d;
  logic                deskew_en_q, deskew_en_d;
  logic                resync_q, resync_d;
  logic                align_q, align_d;
  logic                fail_q, fail_d;
  logic                go_resync, timeout_hit;
  logic                all_lock, good_reached, bad_reached, am_clear;
  am_class_e           am_class;

  assign all_lock = &i_am_lock;
  assign am_clear = !i_enable || !(state_q == ST_VERIFY || state_q == ST_ALIGNED);

  deskew_am_checker #(
    .N_LANES      (N_LANES),
    .GOOD_AM_COUNT(GOOD_AM_COUNT),
    .BAD_AM_LIMIT (BAD_AM_LIMIT)
  ) u_am_checker (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_clear       (am_clear),
    .i_verify      (state_q == ST_VERIFY),
    .i_aligned     (state_q == ST_ALIGNED),
    .i_valid       (i_valid),
    .i_aligned_am  (i_aligned_am),
    .o_class       (am_class),
    .o_good_reached(good_reached),
    .o_bad_reached (bad_reached)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    retry_d     = retry_q;
    go_resync   = 1'b0;
    timeout_hit = 1'b0;
    if (!i_enable) begin
      state_d = ST_IDLE;
      timer_d = '0;
      hold_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          timer_d = '0;
          if (all_lock) state_d = ST_DESKEW;
        end
        ST_DESKEW: begin
          if (i_valid && timer_q != TW'(DESKEW_TIMEOUT - 1)) timer_d = timer_q + 1'b1;
          timeout_hit = i_valid && (timer_q == TW'(DESKEW_TIMEOUT - 1));
          // Abort conditions outrank a simultaneous deskew_done.
          if (i_invalid_skew || timeout_hit || !all_lock) go_resync = 1'b1;
          else if (i_deskew_done) state_d = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (!all_lock || am_class == AM_PARTIAL) go_resync = 1'b1;
          else if (good_reached) begin
            state_d = ST_ALIGNED;
            retry_d = '0;
          end
        end
        ST_ALIGNED: if (!all_lock || bad_reached) go_resync = 1'b1;
        ST_RESYNC: begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HW'(RESYNC_HOLD - 1)) begin
            hold_d  = '0;
            state_d = (retry_q == NB_RETRY'(MAX_RETRY)) ? ST_FAIL : ST_WAIT_LOCK;
          end
        end
        ST_FAIL:      state_d = ST_FAIL;
        default:      state_d = ST_IDLE;
      endcase
      if (go_resync) begin
        state_d = ST_RESYNC;
        hold_d  = '0;
        if (retry_q != NB_RETRY'(MAX_RETRY)) retry_d = retry_q + 1'b1;
      end
    end
    deskew_en_d = (state_d == ST_DESKEW) || (state_d == ST_VERIFY) || (state_d == ST_ALIGNED);
    resync_d    = (state_d == ST_RESYNC);
    align_d     = (state_d == ST_ALIGNED);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      hold_q      <= '0;
      retry_q     <= '0;
      deskew_en_q <= 1'b0;
      resync_q    <= 1'b0;
      align_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      retry_q     <= retry_d;
      deskew_en_q <= deskew_en_d;
      resync_q    <= resync_d;
      align_q     <= align_d;
      fail_q      <= fail_d;
    end
  end

  assign o_deskew_enable = deskew_en_q;
  assign o_resync        = {N_LANES{resync_q}};
  assign o_align_status  = align_q;
  assign o_fail          = fail_q;
  assign o_retry_count   = retry_q;
  assign o_state         = state_q;

`ifdef DESKEW_SEQ_STATS_EN
  // Statistics survive i_enable toggles; only i_reset clears them.
  logic [15:0] loss_cnt_q, loss_cnt_d;
  logic        timeout_seen_q, timeout_seen_d;

  always_comb begin
    loss_cnt_d     = loss_cnt_q;
    timeout_seen_d = timeout_seen_q | timeout_hit;
    if (state_q == ST_ALIGNED && state_d == ST_RESYNC && loss_cnt_q != 16'hFFFF)
      loss_cnt_d = loss_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      loss_cnt_q     <= '0;
      timeout_seen_q <= 1'b0;
    end else begin
      loss_cnt_q     <= loss_cnt_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end

  assign o_align_loss_count = loss_cnt_q;
  assign o_timeout_seen     = timeout_seen_q;
`endif

endmodule

// File: tb/tb_deskew_sequencer.sv
// Self-checking bench for deskew_sequencer: a cycle model of the sequencing
// rules checked every clock, plus directed scenarios with literal expectations.
module tb_deskew_sequencer;

  localparam int N     = 20;
  localparam int TO    = 64;
  localparam int GOOD  = 2;
  localparam int BAD   = 3;
  localparam int HOLD  = 4;
  localparam int MAXR  = 8;
  localparam int NBR   = 4;
  localparam logic [N-1:0] ALL  = 20'hFFFFF;
  localparam logic [N-1:0] PART = 20'hFFF7F;

  localparam int S_IDLE = 0, S_WAIT = 1, S_DESKEW = 2, S_VERIFY = 3;
  localparam int S_ALIGNED = 4, S_RESYNC = 5, S_FAIL = 6;

  logic           i_clock = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_enable = 1'b0;
  logic           i_valid = 1'b0;
  logic [N-1:0]   i_am_lock = '0;
  logic           i_deskew_done = 1'b0;
  logic           i_invalid_skew = 1'b0;
  logic [N-1:0]   i_aligned_am = '0;
  logic           o_deskew_enable;
  logic [N-1:0]   o_resync;
  logic           o_align_status;
  logic           o_fail;
  logic [NBR-1:0] o_retry_count;
  logic [2:0]     o_state;
`ifdef DESKEW_SEQ_STATS_EN
  logic [15:0]    o_align_loss_count;
  logic           o_timeout_seen;
`endif

  int checks = 0;
  int failures = 0;

  deskew_sequencer #(
    .N_LANES(N), .DESKEW_TIMEOUT(TO), .GOOD_AM_COUNT(GOOD), .BAD_AM_LIMIT(BAD),
    .RESYNC_HOLD(HOLD), .MAX_RETRY(MAXR), .NB_RETRY(NBR)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_am_lock(i_am_lock), .i_deskew_done(i_deskew_done),
    .i_invalid_skew(i_invalid_skew), .i_aligned_am(i_aligned_am),
    .o_deskew_enable(o_deskew_enable), .o_resync(o_resync),
    .o_align_status(o_align_status), .o_fail(o_fail),
    .o_retry_count(o_retry_count), .o_state(o_state)
`ifdef DESKEW_SEQ_STATS_EN
    , .o_align_loss_count(o_align_loss_count), .o_timeout_seen(o_timeout_seen)
`endif
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = S_IDLE;
  int m_vcnt = 0, m_good = 0, m_bad = 0, m_hold_left = 0, m_retries = 0;
  int m_loss = 0;
  bit m_tseen = 0;

  task automatic enter_resync();
    m_state     = S_RESYNC;
    m_hold_left = HOLD;
    if (m_retries < MAXR) m_retries++;
  endtask

  task automatic model_step();
    bit locked, any_am, full_am, to;
    locked  = (i_am_lock == ALL);
    any_am  = i_valid && (i_aligned_am != '0);
    full_am = any_am && (i_aligned_am == ALL);
    to      = 0;
    if (i_reset) begin
      m_state = S_IDLE; m_vcnt = 0; m_good = 0; m_bad = 0;
      m_hold_left = 0; m_retries = 0; m_loss = 0; m_tseen = 0;
    end else if (!i_enable) begin
      m_state = S_IDLE; m_vcnt = 0; m_good = 0; m_bad = 0;
      m_hold_left = 0; m_retries = 0;
    end else begin
      case (m_state)
        S_IDLE: m_state = S_WAIT;
        S_WAIT: begin
          m_vcnt = 0; m_good = 0; m_bad = 0;
          if (locked) m_state = S_DESKEW;
        end
        S_DESKEW: begin
          if (i_valid) begin
            m_vcnt++;
            to = (m_vcnt == TO);
          end
          if (to) m_tseen = 1;
          if (i_invalid_skew || to || !locked) enter_resync();
          else if (i_deskew_done) m_state = S_VERIFY;
        end
        S_VERIFY: begin
          if (!locked || (any_am && !full_am)) enter_resync();
          else if (full_am) begin
            m_good++;
            if (m_good == GOOD) begin
              m_state = S_ALIGNED; m_retries = 0; m_bad = 0;
            end
          end
        end
        S_ALIGNED: begin
          if (any_am) m_bad = full_am ? 0 : m_bad + 1;
          if (!locked || m_bad == BAD) begin
            enter_resync();
            if (m_loss < 16'hFFFF) m_loss++;
          end
        end
        S_RESYNC: begin
          m_hold_left--;
          if (m_hold_left == 0) m_state = (m_retries == MAXR) ? S_FAIL : S_WAIT;
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge i_clock) begin
    model_step();
    #1;
    chk("state", 32'(o_state), 32'(m_state));
    chk("deskew_enable", 32'(o_deskew_enable),
        32'(m_state == S_DESKEW || m_state == S_VERIFY || m_state == S_ALIGNED));
    chk("resync", 32'(o_resync), (m_state == S_RESYNC) ? 32'(ALL) : 32'd0);
    chk("align_status", 32'(o_align_status), 32'(m_state == S_ALIGNED));
    chk("fail", 32'(o_fail), 32'(m_state == S_FAIL));
    chk("retry_count", 32'(o_retry_count), 32'(m_retries));
`ifdef DESKEW_SEQ_STATS_EN
    chk("align_loss_count", 32'(o_align_loss_count), 32'(m_loss));
    chk("timeout_seen", 32'(o_timeout_seen), 32'(m_tseen));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n = 0;
    while (o_state !== 3'(st) && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    chk(name, 32'(o_state), 32'(st));
  endtask

  task automatic am_group(input logic [N-1:0] pat);
    i_valid      = 1'b1;
    i_aligned_am = pat;
    step(1);
    i_aligned_am = '0;
  endtask

  task automatic restart();
    i_enable = 1'b0;
    step(1);
    i_enable = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_state"}, 32'(o_state), 32'd0);
    chk({name, "_deskew_en"}, 32'(o_deskew_enable), 32'd0);
    chk({name, "_resync"}, 32'(o_resync), 32'd0);
    chk({name, "_align"}, 32'(o_align_status), 32'd0);
    chk({name, "_fail"}, 32'(o_fail), 32'd0);
    chk({name, "_retry"}, 32'(o_retry_count), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n, vc, cyc;
    step(2);
    i_reset = 1'b0;
    chk_all_zero("reset");

    // Clean bring-up
    i_enable  = 1'b1;
    i_am_lock = ALL;
    wait_state(S_DESKEW, 10, "bringup_deskew");
    i_valid = 1'b1;
    i_deskew_done = 1'b1;
    step(1);
    i_deskew_done = 1'b0;
    chk("bringup_verify", 32'(o_state), S_VERIFY);
    am_group(ALL);
    chk("bringup_one_group", 32'(o_align_status), 32'd0);
    am_group(ALL);
    chk("bringup_align", 32'(o_align_status), 32'd1);
    chk("bringup_retry", 32'(o_retry_count), 32'd0);

    // Alternating partial/full groups keep alignment
    for (int k = 0; k < 5; k++) am_group((k % 2 == 0) ? PART : ALL);
    chk("alternate_align", 32'(o_align_status), 32'd1);
    am_group(ALL);
    am_group(PART);
    am_group(PART);
    chk("two_partial_align", 32'(o_align_status), 32'd1);
    am_group(PART);
    chk("three_partial_align", 32'(o_align_status), 32'd0);
    chk("three_partial_resync", 32'(o_resync), 32'(ALL));
    chk("three_partial_retry", 32'(o_retry_count), 32'd1);
`ifdef DESKEW_SEQ_STATS_EN
    chk("loss_count_one", 32'(o_align_loss_count), 32'd1);
`endif

    // Invalid skew together with deskew_done
    restart();
    wait_state(S_DESKEW, 10, "skew_deskew");
    i_invalid_skew = 1'b1;
    i_deskew_done  = 1'b1;
    step(1);
    i_invalid_skew = 1'b0;
    i_deskew_done  = 1'b0;
    chk("skew_state", 32'(o_state), S_RESYNC);
    n = 0;
    while (o_resync === ALL && n < 20) begin
      n++;
      step(1);
    end
    chk("skew_resync_cycles", 32'(n), 32'd4);
    chk("skew_back_wait", 32'(o_state), S_WAIT);
    chk("skew_retry", 32'(o_retry_count), 32'd1);

    // Timeout counts valid cycles, not clocks
    restart();
    wait_state(S_DESKEW, 10, "timeout_deskew");
    vc = 0;
    cyc = 0;
    while (cyc < 300) begin
      i_valid = cyc[0];
      step(1);
      cyc++;
      if (i_valid) vc++;
      if (o_resync !== '0) break;
    end
    i_valid = 1'b1;
    chk("timeout_valid_cycles", 32'(vc), 32'd64);
    chk("timeout_clock_cycles", 32'(cyc), 32'd128);
`ifdef DESKEW_SEQ_STATS_EN
    chk("timeout_seen", 32'(o_timeout_seen), 32'd1);
`endif

    // Retry exhaustion
    restart();
    for (int k = 0; k < MAXR; k++) begin
      wait_state(S_DESKEW, 20, "exhaust_deskew");
      i_invalid_skew = 1'b1;
      step(1);
      i_invalid_skew = 1'b0;
    end
    wait_state(S_FAIL, 20, "exhaust_fail_state");
    chk("exhaust_fail", 32'(o_fail), 32'd1);
    chk("exhaust_retry", 32'(o_retry_count), 32'd8);
    step(3);
    chk("fail_sticky", 32'(o_state), S_FAIL);
    i_enable = 1'b0;
    step(1);
    chk_all_zero("fail_exit");
    i_enable = 1'b1;

    // Reset in the second RESYNC hold cycle
    wait_state(S_DESKEW, 10, "rst_deskew");
    i_invalid_skew = 1'b1;
    step(1);
    i_invalid_skew = 1'b0;
    step(1);
    chk("rst_in_resync", 32'(o_resync), 32'(ALL));
    i_reset = 1'b1;
    step(1);
    chk_all_zero("rst_mid_resync");
`ifdef DESKEW_SEQ_STATS_EN
    chk("rst_loss_count", 32'(o_align_loss_count), 32'd0);
`endif
    i_reset = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
